// File: rtl/cpu_types_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// Module  : cpu_types_pkg
// Desc    : Shared datapath types and memory-stage state encoding
// Rev     : 1.0
//----------------------------------------------------------------------
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } memstate_t;

  function automatic logic isMemOp(input logic dREN, input logic dWEN);
    return dREN | dWEN;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ex_mem_if.sv
`default_nettype none
//----------------------------------------------------------------------
// Module  : ex_mem_if
// Desc    : EX/MEM latch bundle: EX inputs, data-memory port, MEM outputs
// Rev     : 1.0
//----------------------------------------------------------------------
interface ex_mem_if #(
  parameter int CNT_W = 16
);
  import cpu_types_pkg::*;

  logic             ex_valid, flush, ex_dREN, ex_dWEN;
  logic             ex_regWrite, ex_MemtoReg, ex_HALT;
  regbits_t         ex_wsel;
  word_t            ex_aluout, ex_rdat2, ex_pcp4;
  logic             dhit;
  word_t            dmemload;
  logic             dmemREN, dmemWEN;
  word_t            dmemaddr, dmemstore;
  logic             busy;
  logic             mem_valid, mem_regWrite, mem_MemtoReg, mem_HALT;
  regbits_t         mem_wsel;
  word_t            mem_aluout, mem_pcp4, mem_dload;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;

  modport ex_mem (
    input  ex_valid, flush, ex_dREN, ex_dWEN, ex_regWrite, ex_MemtoReg, ex_HALT,
    input  ex_wsel, ex_aluout, ex_rdat2, ex_pcp4, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, busy,
    output mem_valid, mem_regWrite, mem_MemtoReg, mem_HALT, mem_wsel,
    output mem_aluout, mem_pcp4, mem_dload, halt, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//----------------------------------------------------------------------
// Module  : sat_counter
// Desc    : Up-counter that sticks at all-ones instead of wrapping
// Rev     : 1.0
//----------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
//----------------------------------------------------------------------
// Module  : ex_mem_stage
// Desc    : EX/MEM register with data-memory handshake and sticky halt
// Rev     : 1.0
//----------------------------------------------------------------------
module ex_mem_stage #(
  parameter int CNT_W = 16
) (
  input logic      CLK,
  input logic      nRST,
  ex_mem_if.ex_mem emif
);
  import cpu_types_pkg::*;

  memstate_t        r_state;
  logic             r_valid, r_regWrite, r_MemtoReg, r_HALT, r_dREN, r_dWEN;
  regbits_t         r_wsel;
  word_t            r_aluout, r_rdat2, r_pcp4, r_dload;
  logic             w_access, w_load, w_take, w_exMem, w_stallInc;
  logic [CNT_W-1:0] w_stallCnt;

  assign w_access   = (r_state == ACCESS);
  // The register only advances when no memory access is outstanding.
  assign w_load     = (r_state == IDLE) || (w_access && emif.dhit);
  assign w_take     = emif.ex_valid && !emif.flush;
  assign w_exMem    = w_take && isMemOp(emif.ex_dREN, emif.ex_dWEN);
  assign w_stallInc = w_access && !emif.dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_valid    <= 1'b0;
      r_regWrite <= 1'b0;
      r_MemtoReg <= 1'b0;
      r_HALT     <= 1'b0;
      r_dREN     <= 1'b0;
      r_dWEN     <= 1'b0;
      r_wsel     <= '0;
      r_aluout   <= '0;
      r_rdat2    <= '0;
      r_pcp4     <= '0;
      r_dload    <= '0;
    end else begin
      if (w_access && emif.dhit && r_dREN) begin
        r_dload <= emif.dmemload;
      end
      if (w_load) begin
        r_valid    <= w_take;
        r_regWrite <= w_take && emif.ex_regWrite;
        r_MemtoReg <= w_take && emif.ex_MemtoReg;
        r_HALT     <= w_take && emif.ex_HALT;
        r_dREN     <= w_take && emif.ex_dREN;
        // A combined read/write request is served as a load.
        r_dWEN     <= w_take && emif.ex_dWEN && !emif.ex_dREN;
        if (w_take) begin
          r_wsel   <= emif.ex_wsel;
          r_aluout <= emif.ex_aluout;
          r_rdat2  <= emif.ex_rdat2;
          r_pcp4   <= emif.ex_pcp4;
        end
        if (w_access && r_HALT) begin
          r_state <= HALTED;
        end else if (w_exMem) begin
          r_state <= ACCESS;
        end else if (w_take && emif.ex_HALT) begin
          r_state <= HALTED;
        end else begin
          r_state <= IDLE;
        end
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (w_stallInc),
    .count (w_stallCnt)
  );

  assign emif.dmemREN      = w_access && r_dREN;
  assign emif.dmemWEN      = w_access && r_dWEN;
  assign emif.dmemaddr     = r_aluout;
  assign emif.dmemstore    = r_rdat2;
  assign emif.busy         = w_access ? !emif.dhit : (r_state == HALTED);
  assign emif.halt         = (r_state == HALTED);
  assign emif.mem_valid    = r_valid;
  assign emif.mem_regWrite = r_regWrite;
  assign emif.mem_MemtoReg = r_MemtoReg;
  assign emif.mem_HALT     = r_HALT;
  assign emif.mem_wsel     = r_wsel;
  assign emif.mem_aluout   = r_aluout;
  assign emif.mem_pcp4     = r_pcp4;
  assign emif.mem_dload    = r_dload;
  assign emif.stall_cnt    = w_stallCnt;
endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
//----------------------------------------------------------------------
// Module  : tb_ex_mem_stage
// Desc    : Self-checking bench for ex_mem_stage with a transaction model
// Rev     : 1.0
//----------------------------------------------------------------------
module tb_ex_mem_stage;
  localparam int C_CNT_W = 4;
  localparam int C_MAX   = (1 << C_CNT_W) - 1;

  logic CLK;
  logic nRST;
  int   errors;
  int   checks;

  ex_mem_if #(.CNT_W(C_CNT_W)) emif ();

  ex_mem_stage #(
    .CNT_W (C_CNT_W)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .emif (emif)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic v, f, rd, wr, rw, m2r, h, input logic [4:0] ws,
                        input logic [31:0] alu, r2, pc);
    emif.ex_valid = v;   emif.flush = f;         emif.ex_dREN = rd; emif.ex_dWEN = wr;
    emif.ex_regWrite = rw; emif.ex_MemtoReg = m2r; emif.ex_HALT = h;
    emif.ex_wsel = ws;   emif.ex_aluout = alu;   emif.ex_rdat2 = r2; emif.ex_pcp4 = pc;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    emif.dhit = 1'b0;
    emif.dmemload = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if ({emif.busy, emif.halt, emif.dmemREN, emif.dmemWEN} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", {emif.busy, emif.halt, emif.dmemREN, emif.dmemWEN}); end
    checks++; if ({emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg, emif.mem_HALT, emif.mem_wsel} !== 9'b0) begin errors++; $display("FAIL reset_mem_ctl: got %h expected 0", {emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg, emif.mem_HALT, emif.mem_wsel}); end
    checks++; if ((|{emif.dmemaddr, emif.dmemstore, emif.mem_aluout, emif.mem_pcp4, emif.mem_dload}) !== 1'b0) begin errors++; $display("FAIL reset_data: got nonzero data expected 0"); end
    checks++; if (emif.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", emif.stall_cnt); end
  endtask

  task automatic test_alu();
    do_reset();
    set_ex(1, 0, 0, 0, 1, 0, 0, 5'd5, 32'h1234, 32'hAAAA, 32'h44);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if ({emif.mem_aluout, emif.mem_wsel} !== {32'h1234, 5'd5}) begin errors++; $display("FAIL alu_fields: got %h/%0d expected 1234/5", emif.mem_aluout, emif.mem_wsel); end
    checks++; if ({emif.mem_valid, emif.mem_regWrite, emif.mem_pcp4} !== {2'b11, 32'h44}) begin errors++; $display("FAIL alu_ctl: got %b%b/%h expected 11/44", emif.mem_valid, emif.mem_regWrite, emif.mem_pcp4); end
    checks++; if ({emif.busy, emif.dmemREN, emif.dmemWEN} !== 3'b000) begin errors++; $display("FAIL alu_no_req: got %b expected 000", {emif.busy, emif.dmemREN, emif.dmemWEN}); end
  endtask

  task automatic test_load_wait();
    do_reset();
    set_ex(1, 0, 1, 0, 1, 1, 0, 5'd7, 32'h100, 32'd0, 32'h8);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      emif.dhit = (k == 2);
      emif.dmemload = (k == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      #1;
      checks++; if ({emif.dmemREN, emif.dmemWEN, emif.dmemaddr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL load_req[%0d]: got %b%b@%h expected 10@100", k, emif.dmemREN, emif.dmemWEN, emif.dmemaddr); end
      checks++; if (emif.busy !== (k < 2)) begin errors++; $display("FAIL load_busy[%0d]: got %b expected %b", k, emif.busy, (k < 2)); end
      tick();
    end
    emif.dhit = 1'b0;
    #1;
    checks++; if (emif.mem_dload !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h expected deadbeef", emif.mem_dload); end
    checks++; if (emif.stall_cnt !== 4'd2) begin errors++; $display("FAIL load_stall_cnt: got %0d expected 2", emif.stall_cnt); end
    checks++; if ({emif.dmemREN, emif.busy} !== 2'b00) begin errors++; $display("FAIL load_drop: got %b expected 00", {emif.dmemREN, emif.busy}); end
  endtask

  task automatic test_store_load();
    do_reset();
    set_ex(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'h40, 32'hCAFE0001, 32'h0);
    tick();
    set_ex(1, 0, 1, 0, 1, 1, 0, 5'd9, 32'h80, 32'h0, 32'h0);
    emif.dhit = 1'b1;
    #1;
    checks++; if ({emif.dmemWEN, emif.dmemREN, emif.dmemaddr, emif.dmemstore} !== {2'b10, 32'h40, 32'hCAFE0001}) begin errors++; $display("FAIL st_req: got %b%b@%h=%h expected 10@40=cafe0001", emif.dmemWEN, emif.dmemREN, emif.dmemaddr, emif.dmemstore); end
    checks++; if (emif.busy !== 1'b0) begin errors++; $display("FAIL st_busy: got %b expected 0", emif.busy); end
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    emif.dmemload = 32'h5A5A1234;
    #1;
    checks++; if ({emif.dmemREN, emif.dmemWEN, emif.dmemaddr} !== {2'b10, 32'h80}) begin errors++; $display("FAIL ld_req: got %b%b@%h expected 10@80", emif.dmemREN, emif.dmemWEN, emif.dmemaddr); end
    checks++; if (emif.busy !== 1'b0) begin errors++; $display("FAIL ld_busy: got %b expected 0", emif.busy); end
    tick();
    emif.dhit = 1'b0;
    #1;
    checks++; if ({emif.mem_dload, emif.stall_cnt, emif.dmemREN} !== {32'h5A5A1234, 4'd0, 1'b0}) begin errors++; $display("FAIL stld_end: got %h/%0d/%b expected 5a5a1234/0/0", emif.mem_dload, emif.stall_cnt, emif.dmemREN); end
  endtask

  task automatic test_flush_idle();
    do_reset();
    set_ex(1, 0, 0, 0, 1, 0, 0, 5'd3, 32'h777, 32'd0, 32'h10);
    tick();
    set_ex(1, 1, 1, 0, 1, 1, 0, 5'd4, 32'h888, 32'd0, 32'h20);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if ({emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg} !== 3'b000) begin errors++; $display("FAIL flush_ctl: got %b expected 000", {emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg}); end
    checks++; if ({emif.mem_aluout, emif.mem_wsel} !== {32'h777, 5'd3}) begin errors++; $display("FAIL flush_hold: got %h/%0d expected 777/3", emif.mem_aluout, emif.mem_wsel); end
    checks++; if ({emif.dmemREN, emif.busy} !== 2'b00) begin errors++; $display("FAIL flush_no_req: got %b expected 00", {emif.dmemREN, emif.busy}); end
  endtask

  task automatic test_flush_access();
    do_reset();
    set_ex(1, 0, 1, 0, 1, 0, 0, 5'd3, 32'h200, 32'd0, 32'd0);
    tick();
    set_ex(1, 1, 0, 1, 1, 0, 1, 5'd9, 32'h999, 32'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({emif.busy, emif.dmemREN} !== 2'b11) begin errors++; $display("FAIL flacc_busy[%0d]: got %b expected 11", k, {emif.busy, emif.dmemREN}); end
      tick();
      checks++; if ({emif.mem_valid, emif.mem_wsel} !== {1'b1, 5'd3}) begin errors++; $display("FAIL flacc_hold[%0d]: got %b/%0d expected 1/3", k, emif.mem_valid, emif.mem_wsel); end
    end
    emif.dhit = 1'b1;
    #1;
    checks++; if (emif.busy !== 1'b0) begin errors++; $display("FAIL flacc_dhit_busy: got %b expected 0", emif.busy); end
    tick();
    emif.dhit = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if ({emif.mem_valid, emif.mem_regWrite, emif.halt, emif.dmemWEN, emif.mem_aluout} !== {4'b0000, 32'h200}) begin errors++; $display("FAIL flacc_bubble: got %b/%h expected 0000/200", {emif.mem_valid, emif.mem_regWrite, emif.halt, emif.dmemWEN}, emif.mem_aluout); end
  endtask

  task automatic test_halt();
    do_reset();
    set_ex(1, 0, 0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    set_ex(1, 0, 1, 0, 1, 0, 0, 5'd2, 32'h300, 32'd0, 32'd0);
    #1;
    checks++; if ({emif.halt, emif.busy, emif.mem_HALT} !== 3'b111) begin errors++; $display("FAIL halt_rise: got %b expected 111", {emif.halt, emif.busy, emif.mem_HALT}); end
    for (int k = 0; k < 3; k++) begin
      emif.dhit = k[0];
      tick();
      checks++; if ({emif.halt, emif.busy, emif.dmemREN, emif.mem_HALT} !== 4'b1101) begin errors++; $display("FAIL halt_hold[%0d]: got %b expected 1101", k, {emif.halt, emif.busy, emif.dmemREN, emif.mem_HALT}); end
    end
    emif.dhit = 1'b0;
  endtask

  task automatic test_halt_after_load();
    do_reset();
    set_ex(1, 0, 1, 0, 1, 1, 0, 5'd6, 32'h400, 32'd0, 32'd0);
    tick();
    set_ex(1, 0, 0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (emif.halt !== 1'b0) begin errors++; $display("FAIL hal_early[%0d]: got %b expected 0", k, emif.halt); end
    end
    emif.dhit = 1'b1;
    emif.dmemload = 32'h0F0F0F0F;
    tick();
    emif.dhit = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if ({emif.halt, emif.busy, emif.dmemREN, emif.mem_dload} !== {3'b110, 32'h0F0F0F0F}) begin errors++; $display("FAIL hal_after: got %b/%h expected 110/0f0f0f0f", {emif.halt, emif.busy, emif.dmemREN}, emif.mem_dload); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ex(1, 0, 1, 0, 1, 1, 0, 5'd8, 32'h500, 32'h9, 32'h4);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if (emif.dmemREN !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", emif.dmemREN); end
    nRST = 1'b0;
    #1;
    checks++; if ({emif.dmemREN, emif.busy, emif.mem_valid, emif.mem_wsel, emif.dmemaddr, emif.dmemstore, emif.mem_pcp4} !== '0) begin errors++; $display("FAIL rstmid_async: got %b/%h expected all 0", {emif.dmemREN, emif.busy, emif.mem_valid}, emif.dmemaddr); end
    emif.dhit = 1'b1;
    emif.dmemload = 32'h11112222;
    tick();
    nRST = 1'b1;
    emif.dhit = 1'b0;
    tick();
    checks++; if ({emif.mem_dload, emif.dmemREN, emif.stall_cnt} !== {32'd0, 1'b0, 4'd0}) begin errors++; $display("FAIL rstmid_after: got %h/%b/%0d expected 0/0/0", emif.mem_dload, emif.dmemREN, emif.stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_ex(1, 0, 0, 1, 0, 0, 0, 5'd0, 32'h600, 32'h1, 32'd0);
    tick();
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (emif.stall_cnt !== 4'((k > C_MAX) ? C_MAX : k)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, emif.stall_cnt, (k > C_MAX) ? C_MAX : k); end
    end
    emif.dhit = 1'b1;
    tick();
    emif.dhit = 1'b0;
    checks++; if ({emif.stall_cnt, emif.dmemWEN} !== {4'(C_MAX), 1'b0}) begin errors++; $display("FAIL sat_end: got %0d/%b expected %0d/0", emif.stall_cnt, emif.dmemWEN, C_MAX); end
  endtask

  // Transaction-level model: each issued instruction either becomes a bubble or
  // a latched record; memory ops hold the stage for their chosen extra wait cycles.
  task automatic test_random();
    logic [31:0] eAlu = 0, eR2 = 0, ePc = 0, eDload = 0, pData = 0;
    logic [4:0]  eWs = 0;
    logic        pMem = 0, pLd = 0;
    int          eStall = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic v, f, rd, wr, rw, m2r, tk;
      logic [4:0] ws;
      logic [31:0] alu, r2, pc;
      int kind, dly;
      v = ($urandom_range(3) != 0);
      f = ($urandom_range(4) == 0);
      kind = int'($urandom_range(3));
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      rw = 1'($urandom); m2r = 1'($urandom); ws = 5'($urandom);
      alu = $urandom; r2 = $urandom; pc = $urandom;
      dly = int'($urandom_range(3));
      set_ex(v, f, rd, wr, rw, m2r, 1'b0, ws, alu, r2, pc);
      emif.dhit = pMem;
      emif.dmemload = pData;
      #1;
      checks++; if (emif.busy !== 1'b0) begin errors++; $display("FAIL rnd_issue_busy[%0d]: got %b expected 0", i, emif.busy); end
      checks++; if ({emif.dmemREN, emif.dmemWEN} !== (pMem ? {pLd, !pLd} : 2'b00)) begin errors++; $display("FAIL rnd_hit_req[%0d]: got %b%b expected %b", i, emif.dmemREN, emif.dmemWEN, pMem ? {pLd, !pLd} : 2'b00); end
      tick();
      emif.dhit = 1'b0;
      if (pLd) eDload = pData;
      tk = v && !f;
      if (tk) begin eWs = ws; eAlu = alu; eR2 = r2; ePc = pc; end
      checks++; if ({emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg, emif.mem_HALT} !== {tk, tk & rw, tk & m2r, 1'b0}) begin errors++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, {emif.mem_valid, emif.mem_regWrite, emif.mem_MemtoReg, emif.mem_HALT}, {tk, tk & rw, tk & m2r, 1'b0}); end
      checks++; if ({emif.mem_wsel, emif.mem_aluout, emif.mem_pcp4, emif.mem_dload} !== {eWs, eAlu, ePc, eDload}) begin errors++; $display("FAIL rnd_data[%0d]: got %0d/%h/%h/%h expected %0d/%h/%h/%h", i, emif.mem_wsel, emif.mem_aluout, emif.mem_pcp4, emif.mem_dload, eWs, eAlu, ePc, eDload); end
      checks++; if (emif.stall_cnt !== 4'((eStall > C_MAX) ? C_MAX : eStall)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", i, emif.stall_cnt, (eStall > C_MAX) ? C_MAX : eStall); end
      pMem = tk && (rd || wr);
      pLd = tk && rd;
      pData = $urandom;
      if (pMem) begin
        for (int k = 0; k < dly; k++) begin
          set_ex(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
          #1;
          checks++; if ({emif.busy, emif.dmemREN, emif.dmemWEN, emif.dmemaddr, emif.dmemstore} !== {1'b1, pLd, !pLd, eAlu, eR2}) begin errors++; $display("FAIL rnd_wait[%0d.%0d]: got %b%b%b@%h=%h expected 1%b%b@%h=%h", i, k, emif.busy, emif.dmemREN, emif.dmemWEN, emif.dmemaddr, emif.dmemstore, pLd, !pLd, eAlu, eR2); end
          tick();
          eStall++;
        end
      end
    end
    set_ex(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
    emif.dhit = pMem;
    emif.dmemload = pData;
    tick();
    emif.dhit = 1'b0;
    if (pLd) eDload = pData;
    checks++; if ({emif.mem_dload, emif.stall_cnt, emif.halt} !== {eDload, 4'((eStall > C_MAX) ? C_MAX : eStall), 1'b0}) begin errors++; $display("FAIL rnd_final: got %h/%0d/%b expected %h/%0d/0", emif.mem_dload, emif.stall_cnt, emif.halt, eDload, (eStall > C_MAX) ? C_MAX : eStall); end
  endtask

  initial begin
    CLK = 1'b0;
    nRST = 1'b0;
    errors = 0;
    checks = 0;
    test_reset();
    test_alu();
    test_load_wait();
    test_store_load();
    test_flush_idle();
    test_flush_access();
    test_halt();
    test_halt_after_load();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline stage that consumes the execute-stage results of the instruction issued from the ID/EX latch and holds them in the EX/MEM register. It drives the data-memory request for loads and stores and stalls the front of the pipeline until `dhit`. It then presents register-writeback data to the MEM/WB latch. Once a HALT instruction has retired here, the stage latches halt permanently.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports (name, direction, width, meaning):
- `CLK`, in, 1: clock. This is the block's one clock; all state updates on its rising edge.
- `nRST`, in, 1: reset. Asynchronous, active-low.
- `ex_valid`, in, 1: EX holds a real instruction. When 0, the stage loads a bubble.
- `flush`, in, 1: squash. The stage loads a bubble instead of the EX contents.
- `ex_dREN`, in, 1: load request.
- `ex_dWEN`, in, 1: store request.
- `ex_regWrite`, in, 1: register writeback enable.
- `ex_MemtoReg`, in, 1: writeback data source is memory.
- `ex_HALT`, in, 1: the instruction is a halt.
- `ex_wsel`, in, 5: destination register (`regbits_t`).
- `ex_aluout`, in, 32: ALU result, also used as the memory address.
- `ex_rdat2`, in, 32: store data.
- `ex_pcp4`, in, 32: PC+4, used for link writeback.
- `dhit`, in, 1: data memory completed the current request.
- `dmemload`, in, 32: load data, valid when `dhit` is 1.
- `dmemREN`, out, 1: memory read request.
- `dmemWEN`, out, 1: memory write request.
- `dmemaddr`, out, 32: memory address.
- `dmemstore`, out, 32: memory write data.
- `busy`, out, 1: stall request to the upstream latches and the hazard unit.
- `mem_valid`, `mem_regWrite`, `mem_MemtoReg`, `mem_HALT`, out, 1 each: latched control outputs.
- `mem_wsel`, out, 5: latched destination register.
- `mem_aluout`, `mem_pcp4`, `mem_dload`, out, 32 each: latched data outputs.
- `halt`, out, 1: sticky processor halt.
- `stall_cnt`, out, `CNT_W`: saturating count of cycles spent waiting on `dhit`.

## Operation
State machine states are IDLE, ACCESS and HALTED.

IDLE:
- `busy` is 0.
- Every cycle the EX/MEM register loads.
  - If `flush` is 1 or `ex_valid` is 0, it loads a bubble. A bubble has all control bits 0 and its data fields hold their previous values.
  - Otherwise it loads the EX fields.
- A loaded instruction with `ex_dREN` or `ex_dWEN` set moves the stage to ACCESS.
- A loaded instruction with `ex_HALT` set, and no memory operation, moves the stage to HALTED.

ACCESS:
- `dmemREN`/`dmemWEN` are driven from the latched bits. `dmemaddr` is `mem_aluout`; `dmemstore` is the latched `rdat2`.
- `busy` is `!dhit` (combinational), so upstream advances in the `dhit` cycle.
- `flush` and all EX inputs are ignored while `busy` is 1. A requester must hold `flush` until `busy` is 0.
- On `dhit`, `mem_dload` captures `dmemload` for loads only.
- On `dhit` the register loads the next EX instruction with the IDLE rules. The next state is:
  - ACCESS if that instruction is a memory operation;
  - HALTED if the completed instruction or the new one is a halt;
  - IDLE otherwise.

HALTED:
- `halt` is 1 and `busy` is 1.
- All requests are 0 and every input is ignored.
- The stage leaves HALTED only on reset.

Boundary rules:
- `ex_dREN` and `ex_dWEN` both set: treated as a load; `dmemWEN` is suppressed.
- A memory request is only ever asserted in ACCESS.
- `mem_valid` is 0 for a bubble.
- `stall_cnt` increments in every ACCESS cycle with `dhit` at 0. It saturates at all-ones and never wraps.
- Reset mid-access drops the request asynchronously, goes to IDLE and discards any pending `dhit`.

## Timing
- Reset values:
  - state IDLE;
  - every 1-bit and control output 0, including `busy` and `halt`;
  - every 32-bit output 0;
  - `mem_wsel` 0;
  - `stall_cnt` 0.
- Non-memory instruction latched at edge N: `mem_*` outputs are valid for cycle N+1.
- Memory instruction latched at edge N:
  - request is asserted from cycle N+1;
  - `dhit` arrives in cycle M ≥ N+1;
  - `mem_dload` is valid from cycle M+1;
  - request drops in cycle M+1 unless the next instruction is also a memory operation. In that case the request stays asserted continuously with the new address.
- Back-to-back `dhit` in the first ACCESS cycle gives zero stall cycles.
- `halt` rises one cycle after the halt instruction leaves ACCESS or IDLE.

## Structure
- `word_t` and `regbits_t` come from `cpu_types_pkg`.
- Add `memstate_t` (IDLE, ACCESS, HALTED) to `cpu_types_pkg`.
- Ports are bundled in a new `ex_mem_if` interface with a single `ex_mem` modport, matching the other pipeline latches.
- The stall counter is the natural single sub-module: `sat_counter` (parameter `CNT_W`; ports `CLK`, `nRST`, `inc`, `count`).

## Test plan
- ALU instruction, `ex_aluout`=0x1234, `ex_wsel`=5, `ex_regWrite`=1 → next cycle `mem_aluout`=0x1234, `mem_wsel`=5, `busy`=0, no request.
- Load from 0x100 with `dhit` delayed 3 cycles and `dmemload`=0xDEADBEEF:
  - `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles;
  - `busy`=1 for 2 cycles;
  - `mem_dload`=0xDEADBEEF after the `dhit` edge;
  - `stall_cnt`=2.
- Store then load back-to-back with immediate `dhit`:
  - `dmemWEN` for one cycle with `dmemstore`=`ex_rdat2`;
  - then `dmemREN`;
  - `busy` never 1.
- `flush` asserted in IDLE → `mem_valid`=0, `mem_regWrite`=0, no request.
- `flush` asserted during ACCESS → ignored until `dhit`.
- Halt instruction → `halt`=1 and `busy`=1 held.
- Halt following a load: `halt` rises only after that load's `dhit`.
- Reset asserted mid-access: all outputs 0 immediately.
- Force `stall_cnt` near all-ones with a long wait: it stops at all-ones.
